// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
//
// Purpose: FSM state encoding and UART frame constants.

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } arb_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: rotate req so ptr sits at bit 0, take the lowest set bit,
//          rotate the index back.
// Ports:
//   req   in   N_REQ  request vector
//   ptr   in   IDW    highest-priority index
//   valid out  1      any request set
//   idx   out  IDW    winning index (first set bit at or after ptr)

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  logic [N_REQ-1:0] rot;
  logic [IDW:0]     sum;
  logic [IDW:0]     back;
  logic [IDW-1:0]   off;

  always_comb begin
    rot  = '0;
    sum  = '0;
    back = '0;
    off  = '0;
    // rot[i] = req[(ptr + i) mod N_REQ]
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      rot[i] = req[sum[IDW-1:0]];
    end
    // descending scan so the lowest set offset wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    back = {1'b0, ptr} + {1'b0, off};
    if (back >= (IDW+1)'(N_REQ)) back = back - (IDW+1)'(N_REQ);
    idx   = back[IDW-1:0];
    valid = |req;
  end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter
//
// Purpose: arbitrate N_REQ byte producers, load/trigger the transmitter and
//          time the frame since the transmitter has no done flag.
// Ports:
//   clk            in   1        system clock
//   rst            in   1        synchronous active-high reset
//   req            in   N_REQ    per-requester byte pending
//   data_in        in   8*N_REQ  flat bytes, slice i = [8i+7:8i]
//   ack            out  N_REQ    one-cycle capture pulse
//   grant_id       out  IDW      owner of the current frame
//   busy           out  1        not IDLE
//   uart_data      out  8        captured byte
//   uart_load_byte out  1        load strobe
//   uart_t_byte    out  1        transmit trigger

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BAUD_DIV     = 5208,
  parameter int GUARD_CYCLES = 2,
  parameter int IDW          = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]             ack,
  output logic [IDW-1:0]               grant_id,
  output logic                         busy,
  output logic [UART_DATA_W-1:0]       uart_data,
  output logic                         uart_load_byte,
  output logic                         uart_t_byte
);

  localparam int FRAME_CYCLES = UART_FRAME_BITS * BAUD_DIV + GUARD_CYCLES;
  localparam int CNTW         = $clog2(FRAME_CYCLES + 1);

  arb_state_t             state_q;
  logic [IDW-1:0]         rr_ptr_q;
  logic [CNTW-1:0]        cnt_q;
  logic [N_REQ-1:0]       ack_q;
  logic [IDW-1:0]         grant_q;
  logic [UART_DATA_W-1:0] data_q;
  logic                   load_q;
  logic                   fire_q;

  logic                   pick_valid;
  logic [IDW-1:0]         pick_idx;
  logic [IDW-1:0]         rr_ptr_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rr_ptr_d = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Strobes are set on the edge entering the state in which they must be
  // visible, so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      ack_q  <= '0;
      load_q <= 1'b0;
      fire_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            data_q          <= data_in[{pick_idx, 3'b000} +: UART_DATA_W];
            grant_q         <= pick_idx;
            rr_ptr_q        <= rr_ptr_d;
            ack_q[pick_idx] <= 1'b1;
            load_q          <= 1'b1;
            state_q         <= LOAD;
          end
        end
        LOAD: begin
          fire_q  <= 1'b1;
          state_q <= FIRE;
        end
        FIRE: begin
          cnt_q   <= CNTW'(FRAME_CYCLES - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack            = ack_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != IDLE);
  assign uart_data      = data_q;
  assign uart_load_byte = load_q;
  assign uart_t_byte    = fire_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [31:0]      data_in;
  logic [N_REQ-1:0] ack;
  logic [IDW-1:0]   grant_id;
  logic             busy;
  logic [7:0]       uart_data;
  logic             uart_load_byte;
  logic             uart_t_byte;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .BAUD_DIV     (4),
    .GUARD_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .data_in        (data_in),
    .ack            (ack),
    .grant_id       (grant_id),
    .busy           (busy),
    .uart_data      (uart_data),
    .uart_load_byte (uart_load_byte),
    .uart_t_byte    (uart_t_byte)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ticks until an ack pulse is seen; returns number of cycles taken
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 200);
  endtask

  // runs until busy drops, counting busy cycles and strobes seen
  task automatic frame_tail(output int nb, output int nl, output int nf);
    nb = 0; nl = 0; nf = 0;
    while (busy && nb < 200) begin
      nb++;
      nl += int'(uart_load_byte);
      nf += int'(uart_t_byte);
      tick();
    end
  endtask

  int nb, nl, nf, n, bad;
  logic [7:0] exp_b;

  initial begin
    rst = 1'b1; req = '0; data_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    // 1: idle after reset
    check("rst_ack", ack, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_data", uart_data, 0);
    check("rst_load", uart_load_byte, 0);
    check("rst_tbyte", uart_t_byte, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack != 0 || busy || uart_load_byte || uart_t_byte || uart_data != 0 || grant_id != 0) bad++;
    end
    check("idle_stable", bad, 0);

    // 2: single request on slot 2
    req = 4'b0100; data_in = 32'h00A5_0000;
    tick();
    check("s_ack", ack, 4'b0100);
    check("s_load", uart_load_byte, 1);
    check("s_data", uart_data, 8'hA5);
    check("s_grant", grant_id, 2);
    check("s_tbyte0", uart_t_byte, 0);
    req = '0;
    tick();
    check("s_tbyte", uart_t_byte, 1);
    check("s_load_off", uart_load_byte, 0);
    check("s_ack_off", ack, 0);
    frame_tail(nb, nl, nf);
    check("s_busy_len", nb + 1, 44);
    check("s_fire_cnt", nf, 1);

    // 4: rr_ptr=3, slot 3 wins; slot 0 raised mid-frame waits for frame end
    req = 4'b1000; data_in = 32'h5A00_0000;
    tick();
    check("w_ack3", ack, 4'b1000);
    check("w_grant3", grant_id, 3);
    req = '0;
    repeat (10) tick();
    req = 4'b0001; data_in = 32'h0000_0011;
    wait_ack(n);
    check("w_gap0", n + 10, 45);
    check("w_grant0", grant_id, 0);
    check("w_data0", uart_data, 8'h11);
    req = 4'b0011; data_in = 32'h0000_2211;
    wait_ack(n);
    check("w_gap1", n, 45);
    check("w_grant1", grant_id, 1);
    check("w_data1", uart_data, 8'h22);
    req = '0;
    frame_tail(nb, nl, nf);

    // 6: data_in change during WAIT
    req = 4'b0010; data_in = 32'h0000_3C00;
    tick();
    check("d_ack", ack, 4'b0010);
    check("d_data", uart_data, 8'h3C);
    req = '0;
    repeat (10) tick();
    data_in = 32'h0000_FF00;
    frame_tail(nb, nl, nf);
    check("d_hold", uart_data, 8'h3C);
    check("d_tail_len", nb, 34);
    check("d_no_load", nl, 0);
    check("d_no_fire", nf, 0);

    // 5: reset in WAIT with counter at 20
    req = 4'b0010; data_in = 32'h0000_4D00;
    tick();
    check("r_ack", ack, 4'b0010);
    req = '0;
    repeat (23) tick();
    check("r_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_busy", busy, 0);
    check("r_data", uart_data, 0);
    check("r_grant", grant_id, 0);
    check("r_tbyte", uart_t_byte, 0);
    req = 4'b0110; data_in = 32'h0062_6100;
    tick();
    check("r_post_ack", ack, 4'b0010);
    check("r_post_grant", grant_id, 1);
    check("r_post_data", uart_data, 8'h61);
    req = '0;
    frame_tail(nb, nl, nf);
    check("r_post_len", nb, 44);

    // 3: all four held after fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; data_in = 32'hD3C2_B1A0;
    wait_ack(n);
    check("a_first", n, 1);
    check("a_grant_0", grant_id, 0);
    check("a_data_0", uart_data, 8'hA0);
    for (int i = 1; i <= 4; i++) begin
      wait_ack(n);
      check("a_gap", n, 45);
      check("a_grant", grant_id, i % 4);
      check("a_onehot", ack, 1 << (i % 4));
      exp_b = 8'hA0 + 8'h11 * 8'(i % 4);
      check("a_data", uart_data, exp_b);
    end
    req = '0;
    frame_tail(nb, nl, nf);
    check("a_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
